// File: rtl/clock_group_reset_sequencer.sv
// Clock-group reset sequencer: enables member clocks, holds resets, then releases them in ascending index order.
// Optional CLKSEQ_CLOCK_GATE_EN adds a GATE state that stops masked clocks before a re-reset hold.
`timescale 1ns/1ps
module clock_group_reset_sequencer #(
  parameter int NUM_MEMBERS = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int GATE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NUM_MEMBERS-1:0] req_mask,
  output logic [NUM_MEMBERS-1:0] member_clock_en,
  output logic [NUM_MEMBERS-1:0] member_reset,
  output logic                   seq_done,
  output logic                   busy
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > GATE_CYCLES) ? MAX_HG : GATE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {CLK_OFF, HOLD, RELEASE, RUN, GATE} state_t;

  state_t                 state;
  logic [CW-1:0]          counter;
  logic [NUM_MEMBERS-1:0] pending;
  logic [NUM_MEMBERS-1:0] lowest;

  // Isolate the lowest set bit so releases always go in ascending index order.
  assign lowest = pending & (~pending + NUM_MEMBERS'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= CLK_OFF;
      counter         <= '0;
      pending         <= '1;
      member_reset    <= '1;
      member_clock_en <= '0;
      req_ready       <= 1'b0;
      seq_done        <= 1'b0;
      busy            <= 1'b1;
    end else begin
      seq_done <= 1'b0;
      case (state)
        CLK_OFF: begin
          member_clock_en <= '1;
          counter         <= CW'(HOLD_CYCLES - 1);
          state           <= HOLD;
        end
        HOLD: begin
          if (counter == '0) begin
            member_reset <= member_reset & ~lowest;
            pending      <= pending & ~lowest;
            counter      <= CW'(GAP_CYCLES - 1);
            state        <= RELEASE;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        RELEASE: begin
          if (counter == '0) begin
            if (pending != '0) begin
              member_reset <= member_reset & ~lowest;
              pending      <= pending & ~lowest;
              counter      <= CW'(GAP_CYCLES - 1);
            end else begin
              state     <= RUN;
              seq_done  <= 1'b1;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            counter <= counter - CW'(1);
          end
        end
        RUN: begin
          // An all-zero mask is consumed without leaving RUN.
          if (req_valid && req_mask != '0) begin
            member_reset <= member_reset | req_mask;
            pending      <= req_mask;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
`ifdef CLKSEQ_CLOCK_GATE_EN
            member_clock_en <= member_clock_en & ~req_mask;
            counter         <= CW'(GATE_CYCLES - 1);
            state           <= GATE;
`else
            counter <= CW'(HOLD_CYCLES - 1);
            state   <= HOLD;
`endif
          end
        end
`ifdef CLKSEQ_CLOCK_GATE_EN
        GATE: begin
          if (counter == '0) begin
            member_clock_en <= member_clock_en | pending;
            counter         <= CW'(HOLD_CYCLES - 1);
            state           <= HOLD;
          end else begin
            counter <= counter - CW'(1);
          end
        end
`endif
        default: state <= CLK_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench for clock_group_reset_sequencer with default parameters (N=2, HOLD=8, GAP=4, GATE=2).
`timescale 1ns/1ps
module tb_clock_group_reset_sequencer;

`ifdef CLKSEQ_CLOCK_GATE_EN
  localparam int G = 2;
  localparam logic [1:0] EN_M10 = 2'b01;
`else
  localparam int G = 0;
  localparam logic [1:0] EN_M10 = 2'b11;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_mask = 2'b00;
  logic [1:0] member_clock_en;
  logic [1:0] member_reset;
  logic       seq_done;
  logic       busy;

  int checks = 0;
  int passed = 0;

  clock_group_reset_sequencer #(
    .NUM_MEMBERS(2), .HOLD_CYCLES(8), .GAP_CYCLES(4), .GATE_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .member_clock_en(member_clock_en),
    .member_reset(member_reset), .seq_done(seq_done), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // Reset values while reset is held.
    tick(3);
    chk("rst_clk_en", 32'(member_clock_en), 32'h0);
    chk("rst_mreset", 32'(member_reset), 32'h3);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_done", 32'(seq_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);

    // Power-on sequence; next edge is edge 0.
    reset = 1'b0;
    tick(1);
    chk("po_e0_clk_en", 32'(member_clock_en), 32'h3);
    chk("po_e0_mreset", 32'(member_reset), 32'h3);
    tick(7);
    chk("po_e7_mreset", 32'(member_reset), 32'h3);
    tick(1);
    chk("po_e8_mreset", 32'(member_reset), 32'h2);
    tick(3);
    chk("po_e11_mreset", 32'(member_reset), 32'h2);
    tick(1);
    chk("po_e12_mreset", 32'(member_reset), 32'h0);
    tick(3);
    chk("po_e15_done", 32'(seq_done), 32'h0);
    chk("po_e15_ready", 32'(req_ready), 32'h0);
    tick(1);
    chk("po_e16_done", 32'(seq_done), 32'h1);
    chk("po_e16_ready", 32'(req_ready), 32'h1);
    chk("po_e16_busy", 32'(busy), 32'h0);
    tick(1);
    chk("po_e17_done", 32'(seq_done), 32'h0);
    chk("po_e17_busy", 32'(busy), 32'h0);

    // Re-reset mask=10 accepted at edge k.
    req_valid = 1'b1; req_mask = 2'b10;
    tick(1);
    req_valid = 1'b0; req_mask = 2'b00;
    chk("m10_k_mreset", 32'(member_reset), 32'h2);
    chk("m10_k_ready", 32'(req_ready), 32'h0);
    chk("m10_k_busy", 32'(busy), 32'h1);
    chk("m10_k_clk_en", 32'(member_clock_en), 32'(EN_M10));
    tick(7 + G);
    chk("m10_k7_mreset", 32'(member_reset), 32'h2);
    chk("m10_k7_clk_en", 32'(member_clock_en), 32'h3);
    tick(1);
    chk("m10_k8_mreset", 32'(member_reset), 32'h0);
    tick(3);
    chk("m10_k11_done", 32'(seq_done), 32'h0);
    tick(1);
    chk("m10_k12_done", 32'(seq_done), 32'h1);
    chk("m10_k12_ready", 32'(req_ready), 32'h1);
    tick(2);

    // Re-reset mask=11 with req_valid held for the whole sequence.
    req_valid = 1'b1; req_mask = 2'b11;
    tick(1);
    chk("m11_k_mreset", 32'(member_reset), 32'h3);
    tick(7 + G);
    chk("m11_k7_mreset", 32'(member_reset), 32'h3);
    tick(1);
    chk("m11_k8_mreset", 32'(member_reset), 32'h2);
    tick(4);
    chk("m11_k12_mreset", 32'(member_reset), 32'h0);
    tick(3);
    chk("m11_k15_mreset", 32'(member_reset), 32'h0);
    chk("m11_k15_busy", 32'(busy), 32'h1);
    chk("m11_k15_ready", 32'(req_ready), 32'h0);
    tick(1);
    req_valid = 1'b0; req_mask = 2'b00;
    chk("m11_k16_done", 32'(seq_done), 32'h1);
    chk("m11_k16_ready", 32'(req_ready), 32'h1);
    tick(1);
    chk("m11_k17_mreset", 32'(member_reset), 32'h0);
    chk("m11_k17_busy", 32'(busy), 32'h0);

    // Zero mask in RUN: consumed, nothing changes.
    req_valid = 1'b1; req_mask = 2'b00;
    tick(1);
    req_valid = 1'b0;
    chk("m00_mreset", 32'(member_reset), 32'h0);
    chk("m00_clk_en", 32'(member_clock_en), 32'h3);
    chk("m00_busy", 32'(busy), 32'h0);
    chk("m00_ready", 32'(req_ready), 32'h1);
    chk("m00_done", 32'(seq_done), 32'h0);
    tick(2);
    chk("m00_later_done", 32'(seq_done), 32'h0);
    chk("m00_later_busy", 32'(busy), 32'h0);

    // Reset asserted at edge 10 of a power-on sequence.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(11);
    chk("mid_e10_mreset", 32'(member_reset), 32'h2);
    reset = 1'b1;
    #1;
    chk("mid_async_clk_en", 32'(member_clock_en), 32'h0);
    chk("mid_async_mreset", 32'(member_reset), 32'h3);
    chk("mid_async_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    tick(1);
    chk("re_e0_clk_en", 32'(member_clock_en), 32'h3);
    tick(7);
    chk("re_e7_mreset", 32'(member_reset), 32'h3);
    tick(1);
    chk("re_e8_mreset", 32'(member_reset), 32'h2);
    tick(4);
    chk("re_e12_mreset", 32'(member_reset), 32'h0);
    tick(4);
    chk("re_e16_done", 32'(seq_done), 32'h1);
    tick(1);

`ifdef CLKSEQ_CLOCK_GATE_EN
    // Gated re-reset of member 0 only.
    req_valid = 1'b1; req_mask = 2'b01;
    tick(1);
    req_valid = 1'b0; req_mask = 2'b00;
    chk("g_k_clk_en", 32'(member_clock_en), 32'h2);
    chk("g_k_mreset", 32'(member_reset), 32'h1);
    tick(1);
    chk("g_k1_clk_en", 32'(member_clock_en), 32'h2);
    tick(1);
    chk("g_k2_clk_en", 32'(member_clock_en), 32'h3);
    tick(7);
    chk("g_k9_mreset", 32'(member_reset), 32'h1);
    tick(1);
    chk("g_k10_mreset", 32'(member_reset), 32'h0);
    tick(4);
    chk("g_k14_done", 32'(seq_done), 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
